// File: rtl/candidate_feeder_if.sv
// Handshake and data bundle between the candidate feeder and its host/filter.
// master: the host side; it loads candidates, starts streaming and returns Filter_Save.
// slave: the feeder side; it streams candidates and reports ID, Saved_Count and status.
interface candidate_feeder_if #(
  parameter int Q_Width       = 6,
  parameter int LLR_Width     = 5,
  parameter int Counter_Width = 4,
  parameter int Depth         = 2**(Counter_Width+1)-1
);
  logic                   Load_Valid;
  logic [Q_Width:0]       Load_Q;
  logic [LLR_Width:0]     Load_LLR;
  logic                   Start;
  logic                   Filter_Save;
  logic [Q_Width:0]       Output_Q;
  logic [LLR_Width:0]     Output_LLR;
  logic                   Output_Valid;
  logic [Depth:0]         ID;
  logic [Counter_Width+1:0] Saved_Count;
  logic                   Load_Full;
  logic                   Busy;
  logic                   Done;

  modport master (
    output Load_Valid, Load_Q, Load_LLR, Start, Filter_Save,
    input  Output_Q, Output_LLR, Output_Valid, ID, Saved_Count, Load_Full, Busy, Done
  );

  modport slave (
    input  Load_Valid, Load_Q, Load_LLR, Start, Filter_Save,
    output Output_Q, Output_LLR, Output_Valid, ID, Saved_Count, Load_Full, Busy, Done
  );
endinterface

// File: rtl/candidate_feeder.sv
// Buffers up to 2**List_Width candidates, then streams them one per 2 cycles to a duplicate filter.
// Ports: clk, rst_n (async active-low), bus (slave modport of candidate_feeder_if).
// Latency: first Output_Valid 1 cycle after Start; Filter_Save sampled the cycle after each issue.
module candidate_feeder #(
  parameter int Q_Width       = 6,
  parameter int LLR_Width     = 5,
  parameter int Counter_Width = 4,
  parameter int Depth         = 2**(Counter_Width+1)-1,
  parameter int List_Width    = 5
) (
  input logic               clk,
  input logic               rst_n,
  candidate_feeder_if.slave bus
);
  localparam int ListLen = 2**List_Width;
  localparam logic [Counter_Width+1:0] SatCount = (Counter_Width+2)'(Depth+1);
  localparam logic [List_Width:0]      PtrOne   = (List_Width+1)'(1);
  localparam logic [Counter_Width+1:0] CntOne   = (Counter_Width+2)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

  state_t state, next_state;

  logic [Q_Width:0]         list_q   [ListLen];
  logic [LLR_Width:0]       list_llr [ListLen];
  logic [List_Width:0]      wr_ptr, rd_ptr;
  logic [Q_Width:0]         last_q;
  logic [LLR_Width:0]       last_llr;
  logic [Q_Width:0]         cur_q;
  logic [LLR_Width:0]       cur_llr;
  logic [Depth:0]           id, id_shift, id_next;
  logic [Counter_Width+1:0] saved_count;
  logic                     load_ok, start_ok, save_ok;

  // Loads and Start are only honoured in IDLE; Filter_Save only in WAIT.
  assign load_ok  = (state == IDLE) && bus.Load_Valid && !wr_ptr[List_Width];
  assign start_ok = (state == IDLE) && bus.Start;
  assign save_ok  = (state == WAIT) && bus.Filter_Save;

  // Shifting in a one keeps ID a thermometer code.
  assign id_shift = {id[Depth-1:0], 1'b1};
  assign id_next  = save_ok ? id_shift : id;

  assign cur_q   = list_q[rd_ptr[List_Width-1:0]];
  assign cur_llr = list_llr[rd_ptr[List_Width-1:0]];

  // During ISSUE the list entry is shown directly; otherwise the last issued value is held.
  assign bus.Output_Q    = (state == ISSUE) ? cur_q : last_q;
  assign bus.Output_LLR  = (state == ISSUE) ? cur_llr : last_llr;
  assign bus.ID          = id;
  assign bus.Saved_Count = saved_count;
  assign bus.Load_Full   = wr_ptr[List_Width];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state       = state;
    bus.Output_Valid = 1'b0;
    bus.Busy         = 1'b1;
    bus.Done         = 1'b0;
    case (state)
      IDLE: begin
        bus.Busy = 1'b0;
        // A load in the same cycle as Start counts towards a non-empty list.
        if (bus.Start) begin
          next_state = ((wr_ptr != '0) || load_ok) ? ISSUE : FIN;
        end
      end
      ISSUE: begin
        bus.Output_Valid = 1'b1;
        next_state       = WAIT;
      end
      WAIT: begin
        // rd_ptr was already advanced in ISSUE, so equality means the list is exhausted.
        if ((&id_next) || (rd_ptr == wr_ptr)) begin
          next_state = FIN;
        end else begin
          next_state = ISSUE;
        end
      end
      FIN: begin
        bus.Done   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      id          <= '0;
      saved_count <= '0;
      last_q      <= '0;
      last_llr    <= '0;
    end else begin
      if (load_ok) begin
        wr_ptr <= wr_ptr + PtrOne;
      end
      if (start_ok) begin
        rd_ptr      <= '0;
        id          <= '0;
        saved_count <= '0;
      end
      if (state == ISSUE) begin
        last_q   <= cur_q;
        last_llr <= cur_llr;
        rd_ptr   <= rd_ptr + PtrOne;
      end
      if (save_ok) begin
        id <= id_shift;
        if (saved_count != SatCount) begin
          saved_count <= saved_count + CntOne;
        end
      end
      if (state == FIN) begin
        wr_ptr <= '0;
      end
    end
  end

  // List storage carries no reset; stale entries are never read past wr_ptr.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      list_q[wr_ptr[List_Width-1:0]]   <= bus.Load_Q;
      list_llr[wr_ptr[List_Width-1:0]] <= bus.Load_LLR;
    end
  end

endmodule

// File: tb/tb_candidate_feeder.sv
module tb_candidate_feeder;
  localparam int QW = 7;
  localparam int LW = 6;
  localparam int LIST_LEN = 32;
  localparam int MAX_SAVES = 32;

  typedef struct {
    logic [QW-1:0] q;
    logic [LW-1:0] llr;
  } entry_t;

  typedef struct {
    logic [QW-1:0] q;
    logic [LW-1:0] llr;
    int            cyc;
  } exp_out_t;

  typedef struct {
    logic [31:0] id;
    int          cnt;
    int          cyc;
  } exp_done_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  entry_t    model_list[$];
  exp_out_t  exp_q[$];
  exp_done_t exp_done[$];
  logic [QW-1:0] hold_q;
  logic [LW-1:0] hold_llr;
  bit fixed_pat[64];

  candidate_feeder_if bus ();

  candidate_feeder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor / scoreboard: pops expectations whenever the DUT shows a candidate or Done.
  always @(negedge clk) begin
    exp_out_t  e;
    exp_done_t d;
    if (!rst_n) begin
      hold_q   = '0;
      hold_llr = '0;
    end else begin
      if (bus.Output_Valid) begin
        chk("busy_on_issue", 64'(bus.Busy), 64'd1);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output_valid");
        end else begin
          e = exp_q.pop_front();
          chk("out_q", 64'(bus.Output_Q), 64'(e.q));
          chk("out_llr", 64'(bus.Output_LLR), 64'(e.llr));
          chk("issue_cycle", 64'(cyc), 64'(e.cyc));
          hold_q   = e.q;
          hold_llr = e.llr;
        end
      end else begin
        chk("hold_q", 64'(bus.Output_Q), 64'(hold_q));
        chk("hold_llr", 64'(bus.Output_LLR), 64'(hold_llr));
      end
      if (bus.Done) begin
        if (exp_done.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          d = exp_done.pop_front();
          chk("done_id", 64'(bus.ID), 64'(d.id));
          chk("done_saved_count", 64'(bus.Saved_Count), 64'(d.cnt));
          chk("done_cycle", 64'(cyc), 64'(d.cyc));
          chk("busy_on_done", 64'(bus.Busy), 64'd1);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.Output_Valid), 64'd0);
    chk({tag, "_done"}, 64'(bus.Done), 64'd0);
    chk({tag, "_busy"}, 64'(bus.Busy), 64'd0);
    chk({tag, "_full"}, 64'(bus.Load_Full), 64'd0);
    chk({tag, "_q"}, 64'(bus.Output_Q), 64'd0);
    chk({tag, "_llr"}, 64'(bus.Output_LLR), 64'd0);
    chk({tag, "_id"}, 64'(bus.ID), 64'd0);
    chk({tag, "_cnt"}, 64'(bus.Saved_Count), 64'd0);
  endtask

  task automatic load_one(input logic [QW-1:0] q, input logic [LW-1:0] llr);
    entry_t en;
    @(negedge clk);
    bus.Load_Valid  = 1'b1;
    bus.Load_Q      = q;
    bus.Load_LLR    = llr;
    bus.Start       = 1'b0;
    bus.Filter_Save = 1'($urandom_range(0, 1));
    if (model_list.size() < LIST_LEN) begin
      en.q = q;
      en.llr = llr;
      model_list.push_back(en);
    end
    @(negedge clk);
    bus.Load_Valid = 1'b0;
    chk("load_full", 64'(bus.Load_Full), 64'(model_list.size() == LIST_LEN));
    chk("idle_busy", 64'(bus.Busy), 64'd0);
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) begin
      load_one(QW'($urandom), LW'($urandom));
    end
  endtask

  // mode 0: random saves, 1: always save, 2: fixed_pat. abort3 resets after the 3rd issue.
  task automatic run_stream(input int mode, input bit with_load, input bit abort3);
    bit        pat[64];
    int        n, saves, issued, p, k, guard;
    bit        prev_valid, seen_done;
    entry_t    en;
    exp_out_t  e;
    exp_done_t d;
    for (int i = 0; i < 64; i++) begin
      pat[i] = (mode == 1) ? 1'b1 : (mode == 2) ? fixed_pat[i] : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.Start       = 1'b1;
    bus.Filter_Save = 1'($urandom_range(0, 1));
    if (with_load) begin
      bus.Load_Valid = 1'b1;
      bus.Load_Q     = QW'($urandom);
      bus.Load_LLR   = LW'($urandom);
      if (model_list.size() < LIST_LEN) begin
        en.q = bus.Load_Q;
        en.llr = bus.Load_LLR;
        model_list.push_back(en);
      end
    end
    p = cyc + 1;
    n = model_list.size();
    saves = 0;
    issued = 0;
    for (int i = 0; i < n; i++) begin
      e.q = model_list[i].q;
      e.llr = model_list[i].llr;
      e.cyc = p + 2 * i;
      exp_q.push_back(e);
      issued = i + 1;
      if (pat[i]) saves++;
      if (saves == MAX_SAVES) break;
    end
    d.id  = 32'((64'd1 << saves) - 64'd1);
    d.cnt = saves;
    d.cyc = p + 2 * issued;
    exp_done.push_back(d);
    model_list.delete();

    @(negedge clk);
    k = 0;
    guard = 0;
    prev_valid = 1'b0;
    seen_done = 1'b0;
    while (!seen_done && guard < 200) begin
      bus.Start = 1'b0;
      bus.Load_Valid = 1'b0;
      if (bus.Done) begin
        seen_done = 1'b1;
      end else if (bus.Output_Valid) begin
        // Saves presented during ISSUE must be ignored.
        bus.Filter_Save = 1'($urandom_range(0, 1));
        k++;
        prev_valid = 1'b1;
        if (abort3 && k == 3) begin
          #2 rst_n = 1'b0;
          #1 check_all_zero("async_reset");
          exp_q.delete();
          exp_done.delete();
          repeat (2) @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end else if (prev_valid) begin
        // WAIT: real save decision, plus stray Start/Load that must be dropped.
        bus.Filter_Save = pat[k-1];
        bus.Start       = 1'($urandom_range(0, 1));
        bus.Load_Valid  = 1'($urandom_range(0, 1));
        bus.Load_Q      = QW'($urandom);
        bus.Load_LLR    = LW'($urandom);
        prev_valid = 1'b0;
      end else begin
        bus.Filter_Save = 1'($urandom_range(0, 1));
      end
      if (!seen_done) begin
        @(negedge clk);
        guard++;
      end
    end
    if (!seen_done) fail_now("done_timeout");
    bus.Start = 1'b0;
    bus.Load_Valid = 1'b0;
    @(negedge clk);
    chk("post_stream_busy", 64'(bus.Busy), 64'd0);
    chk("post_stream_full", 64'(bus.Load_Full), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    hold_q = '0;
    hold_llr = '0;
    rst_n = 1'b0;
    bus.Load_Valid = 1'b0;
    bus.Load_Q = '0;
    bus.Load_LLR = '0;
    bus.Start = 1'b0;
    bus.Filter_Save = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");

    // Directed: Q=3,7,3,9 with saves 1,1,0,1.
    for (int i = 0; i < 64; i++) fixed_pat[i] = 1'b0;
    fixed_pat[0] = 1'b1;
    fixed_pat[1] = 1'b1;
    fixed_pat[2] = 1'b0;
    fixed_pat[3] = 1'b1;
    load_one(7'd3, 6'd10);
    load_one(7'd7, 6'd20);
    load_one(7'd3, 6'd30);
    load_one(7'd9, 6'd40);
    run_stream(2, 1'b0, 1'b0);

    // Empty list.
    run_stream(0, 1'b0, 1'b0);

    // 33 loads, always save: full mask and 32 saves.
    load_random(33);
    run_stream(1, 1'b0, 1'b0);

    // 32 loads, always save: mask full and list exhausted together.
    load_random(32);
    run_stream(1, 1'b0, 1'b0);

    // Reset after the 3rd issue, then resume normally.
    load_random(6);
    run_stream(1, 1'b0, 1'b1);
    model_list.delete();
    @(negedge clk);
    chk("reset_resume_id", 64'(bus.ID), 64'd0);
    load_random(5);
    run_stream(0, 1'b0, 1'b0);

    // Start together with a load.
    run_stream(0, 1'b1, 1'b0);

    // Randomized sessions.
    for (int it = 0; it < 8; it++) begin
      load_random($urandom_range(0, 36));
      run_stream($urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("leftover_outputs", 64'(exp_q.size()), 64'd0);
    chk("leftover_dones", 64'(exp_done.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
